// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the sequential radix-4 Booth multiplier.
//   state_t    - controller states (IDLE, CALC, DONE)
//   digit_t    - radix-4 Booth digit (ZERO, P1, P2, M1, M2)
//   iter_steps - number of recoding steps for an N-bit operand (N/2 + 1)
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_t;

    // Operands are extended to N+2 bits so that an unsigned operand with its MSB
    // set still reads as positive; N+2 bits need (N+2)/2 = N/2+1 digits.
    function automatic int iter_steps(input int n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// booth_r4_enc: combinational radix-4 Booth recoder.
//   win   [2:0] - {x[2i+1], x[2i], previous bit}
//   digit       - recoded digit in {-2, -1, 0, +1, +2}
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] win,
    output digit_t     digit
);

    always_comb begin
        digit = ZERO;
        case (win)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-4 Booth multiplier, one digit per clock,
// with valid/ready handshakes and a run-time signed/unsigned mode.
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    - operand handshake; x (multiplier), y (multiplicand), tc (1 = signed)
//   out_valid/out_ready  - result handshake
//   prod [2N-1:0]        - exact full product
//   res  [N-1:0]         - fixed-point window prod[N-1+FRAC:FRAC]
//   sat_ovf              - window overflow flag
// Optional feature: define BOOTH_SAT_EN to saturate res to the operand-mode range
// and raise sat_ovf when prod >> FRAC does not fit; otherwise res wraps and
// sat_ovf is 0.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int N    = 16,
    parameter int FRAC = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           tc,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] prod,
    output logic [N-1:0]   res,
    output logic           sat_ovf
);

    localparam int ITER = iter_steps(N);
    localparam int XW   = N + 2;       // extended operand width
    localparam int SW   = N + 4;       // partial-sum width (covers 2*y plus carry room)
    localparam int AW   = 2 * N + 4;   // accumulator width
    localparam int CW   = $clog2(ITER + 1);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    logic [XW-1:0]  x_reg, y_reg;
    logic           prev_reg;
    logic [AW-1:0]  acc_reg, acc_next;
    logic [2*N-1:0] prod_reg;
    logic [N-1:0]   res_reg, res_next;
    logic           sat_reg, sat_next;
    logic           accept, last_step;
    digit_t         digit;
    logic [SW-1:0]  y_ext, pp, sum;

    booth_r4_enc u_enc (
        .win   ({x_reg[1:0], prev_reg}),
        .digit (digit)
    );

    // ---------------- control ----------------
    assign last_step = (cnt_reg == CW'(ITER - 1));

    always_comb begin
        state_next = state_reg;
        in_ready   = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
        accept     = in_valid && in_ready;
        case (state_reg)
            IDLE: if (accept) state_next = CALC;
            CALC: if (last_step) state_next = DONE;
            DONE: if (out_ready) state_next = accept ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // ---------------- datapath ----------------
    assign y_ext = {{2{y_reg[XW-1]}}, y_reg};

    always_comb begin
        pp = '0;
        case (digit)
            P1:      pp = y_ext;
            P2:      pp = y_ext << 1;
            M1:      pp = -y_ext;
            M2:      pp = -(y_ext << 1);
            default: pp = '0;
        endcase
    end

    // Add the digit at bit N+2, then arithmetic shift right by 2. After ITER steps
    // the total shift of N+2 lines the product up with bit 0; nothing is lost since
    // every addition lands above the bits that get shifted out.
    assign sum      = {{2{acc_reg[AW-1]}}, acc_reg[AW-1:N+2]} + pp;
    assign acc_next = {sum, acc_reg[N+1:2]};

`ifdef BOOTH_SAT_EN
    // Mode is only needed after accept to pick the saturation range.
    logic            tc_reg;
    logic [AW-1:0]   shifted;

    // acc_next holds the product sign-extended (signed) or zero-extended
    // (unsigned), so the range test can look at all accumulator bits.
    assign shifted = $signed(acc_next) >>> FRAC;

    always_comb begin
        res_next = shifted[N-1:0];
        sat_next = 1'b0;
        if (tc_reg) begin
            if (!((&shifted[AW-1:N-1]) || !(|shifted[AW-1:N-1]))) begin
                res_next = shifted[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                sat_next = 1'b1;
            end
        end else begin
            if (|shifted[AW-1:N]) begin
                res_next = '1;
                sat_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      tc_reg <= 1'b0;
        else if (accept) tc_reg <= tc;
    end
`else
    assign res_next = acc_next[N-1+FRAC:FRAC];
    assign sat_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            prev_reg <= 1'b0;
            acc_reg  <= '0;
            prod_reg <= '0;
            res_reg  <= '0;
            sat_reg  <= 1'b0;
        end else if (accept) begin
            x_reg    <= {{2{tc & x[N-1]}}, x};
            y_reg    <= {{2{tc & y[N-1]}}, y};
            prev_reg <= 1'b0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
        end else if (state_reg == CALC) begin
            acc_reg  <= acc_next;
            x_reg    <= {2'b00, x_reg[XW-1:2]};
            prev_reg <= x_reg[1];
            cnt_reg  <= cnt_reg + 1'b1;
            if (last_step) begin
                prod_reg <= acc_next[2*N-1:0];
                res_reg  <= res_next;
                sat_reg  <= sat_next;
            end
        end
    end

    assign out_valid = (state_reg == DONE);
    assign prod      = prod_reg;
    assign res       = res_reg;
    assign sat_ovf   = sat_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // main DUT: N=8, FRAC=0
    logic        in_valid = 1'b0, tc = 1'b0, out_ready = 1'b0;
    logic [7:0]  x = '0, y = '0;
    logic        in_ready, out_valid, sat_ovf;
    logic [15:0] prod;
    logic [7:0]  res;

    // second DUT: N=8, FRAC=4
    logic        in_valid2 = 1'b0, tc2 = 1'b0, out_ready2 = 1'b0;
    logic [7:0]  x2 = '0, y2 = '0;
    logic        in_ready2, out_valid2, sat_ovf2;
    logic [15:0] prod2;
    logic [7:0]  res2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.N(8), .FRAC(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .tc(tc), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .res(res), .sat_ovf(sat_ovf)
    );

    booth_mult_seq #(.N(8), .FRAC(4)) dut_frac (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .tc(tc2), .x(x2), .y(y2), .out_valid(out_valid2), .out_ready(out_ready2),
        .prod(prod2), .res(res2), .sat_ovf(sat_ovf2)
    );

    // Present operands at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic t);
        int n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        x = a; y = b; tc = t; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts falling edges until out_valid; lat = number of rising edges since accept.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL wait_valid: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, prod, res, sat_ovf} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b prod=%h res=%h sat=%b, required 1 0 0000 00 0",
                     in_ready, out_valid, prod, res, sat_ovf);
        end
        $display("reset: in_ready=%b out_valid=%b prod=%h", in_ready, out_valid, prod);
    endtask

    task automatic test_signed_min();
        int lat;
        issue(8'h80, 8'h80, 1'b1);
        wait_valid(lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL latency: got %0d cycles, required 5", lat); end
        checks++;
        if (prod !== 16'h4000) begin errors++; $display("FAIL signed_min prod: got %h, required 4000", prod); end
        checks++;
`ifdef BOOTH_SAT_EN
        if ({res, sat_ovf} !== {8'h7F, 1'b1}) begin
            errors++; $display("FAIL signed_min res: got %h/%b, required 7f/1", res, sat_ovf);
        end
`else
        if ({res, sat_ovf} !== {8'h00, 1'b0}) begin
            errors++; $display("FAIL signed_min res: got %h/%b, required 00/0", res, sat_ovf);
        end
`endif
        $display("signed -128 x -128: prod=%h res=%h sat=%b lat=%0d", prod, res, sat_ovf, lat);
        retire();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL retire: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_unsigned_max();
        int lat;
        issue(8'hFF, 8'hFF, 1'b0);
        wait_valid(lat);
        checks++;
        if (prod !== 16'hFE01) begin errors++; $display("FAIL unsigned_max prod: got %h, required fe01", prod); end
        checks++;
`ifdef BOOTH_SAT_EN
        if ({res, sat_ovf} !== {8'hFF, 1'b1}) begin
            errors++; $display("FAIL unsigned_max res: got %h/%b, required ff/1", res, sat_ovf);
        end
`else
        if ({res, sat_ovf} !== {8'h01, 1'b0}) begin
            errors++; $display("FAIL unsigned_max res: got %h/%b, required 01/0", res, sat_ovf);
        end
`endif
        $display("unsigned 255 x 255: prod=%h res=%h sat=%b", prod, res, sat_ovf);
        retire();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        issue(8'd7, 8'hFD, 1'b1);
        wait_valid(lat);
        checks++;
        if ({prod, res, sat_ovf} !== {16'hFFEB, 8'hEB, 1'b0}) begin
            errors++; $display("FAIL 7x-3: prod=%h res=%h sat=%b, required ffeb eb 0", prod, res, sat_ovf);
        end
        $display("signed 7 x -3: prod=%h res=%h", prod, res);
        for (int i = 0; i < 10; i++) begin
            x = 8'd9; y = 8'd9; in_valid = 1'b1;   // must be ignored while out_ready is low
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || prod !== 16'hFFEB) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL backpressure: %0d bad cycles, last out_valid=%b in_ready=%b prod=%h, required 1 0 ffeb",
                               bad, out_valid, in_ready, prod);
        end
        x = 8'd3; y = 8'd5; tc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready with out_ready: got %b, required 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL same-edge accept: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        wait_valid(lat);
        checks++;
        if (prod !== 16'd15 || lat !== 5) begin
            errors++; $display("FAIL back_to_back 3x5: prod=%0d lat=%0d, required 15 5", prod, lat);
        end
        $display("back-to-back 3 x 5: prod=%0d lat=%0d", prod, lat);
        retire();
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        issue(8'd12, 8'd13, 1'b1);
        repeat (2) @(negedge clk);   // two steps done, step 2 next
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, prod, res, sat_ovf} !== {1'b0, 16'h0, 8'h0, 1'b0}) begin
            errors++; $display("FAIL async reset: out_valid=%b prod=%h res=%h sat=%b, required 0 0000 00 0",
                               out_valid, prod, res, sat_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod !== 16'h0) begin
            errors++; $display("FAIL after reset release: in_ready=%b out_valid=%b prod=%h, required 1 0 0000",
                               in_ready, out_valid, prod);
        end
        issue(8'd3, 8'd5, 1'b0);
        wait_valid(lat);
        checks++;
        if (prod !== 16'd15) begin errors++; $display("FAIL post-reset 3x5: prod=%0d, required 15", prod); end
        $display("post-reset 3 x 5: prod=%0d", prod);
        retire();
    endtask

    task automatic test_frac();
        int n = 0;
        x2 = 8'd127; y2 = 8'd127; tc2 = 1'b1; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        while (!out_valid2 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (prod2 !== 16'h3F01 || out_valid2 !== 1'b1) begin
            errors++; $display("FAIL frac4 prod: out_valid=%b prod=%h, required 1 3f01", out_valid2, prod2);
        end
        checks++;
`ifdef BOOTH_SAT_EN
        if ({res2, sat_ovf2} !== {8'h7F, 1'b1}) begin
            errors++; $display("FAIL frac4 res: got %h/%b, required 7f/1", res2, sat_ovf2);
        end
`else
        if ({res2, sat_ovf2} !== {8'hF0, 1'b0}) begin
            errors++; $display("FAIL frac4 res: got %h/%b, required f0/0", res2, sat_ovf2);
        end
`endif
        $display("FRAC=4 127 x 127: prod=%h res=%h sat=%b", prod2, res2, sat_ovf2);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    // Back-to-back random operands, each result compared with a native multiply.
    task automatic test_random(input logic mode, input int count);
        logic [7:0]  a, b;
        logic [15:0] expv;
        int          p, lat;
        a = 8'($urandom); b = 8'($urandom);
        p = mode ? int'($signed(a)) * int'($signed(b)) : int'(a) * int'(b);
        expv = p[15:0];
        issue(a, b, mode);
        for (int i = 0; i < count; i++) begin
            wait_valid(lat);
            checks++;
            if (prod !== expv) begin
                errors++; $display("FAIL random tc=%b %h x %h: prod=%h, required %h", mode, a, b, prod, expv);
            end
            $display("random tc=%b %h x %h = %h", mode, a, b, prod);
            if (i < count - 1) begin
                a = 8'($urandom); b = 8'($urandom);
                x = a; y = b; tc = mode; in_valid = 1'b1;
                p = mode ? int'($signed(a)) * int'($signed(b)) : int'(a) * int'(b);
                expv = p[15:0];
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b0;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_signed_min();
        test_unsigned_max();
        test_backpressure();
        test_frac();
        test_reset_mid_calc();
        test_random(1'b1, 3000);
        test_random(1'b0, 3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
